// File: rtl/execute_unit_md.sv
// RV32I execute stage with operand forwarding, branch compare, single-cycle ALU,
// an iterative radix-2 M-extension unit with stall handshake, and the EX/MEM register.
module execute_unit_md #(
    parameter int XLEN  = 32,
    parameter bit MD_EN = 1'b1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            ex_valid,
    input  logic            ex_flush,
    input  logic [XLEN-1:0] ex_pc,
    input  logic [XLEN-1:0] ex_DataA,
    input  logic [XLEN-1:0] ex_DataB,
    input  logic [XLEN-1:0] imm,
    input  logic [XLEN-1:0] mem_ALU_out,
    input  logic [XLEN-1:0] wb_WBData,
    input  logic [1:0]      ForwardASel,
    input  logic [1:0]      ForwardBSel,
    input  logic            id_ASel,
    input  logic            id_BSel,
    input  logic            id_BrUn,
    input  logic [3:0]      ex_ALUSel,
    input  logic            ex_is_md,
    input  logic [2:0]      ex_MDSel,
    output logic            ex_BrEq,
    output logic            ex_BrLT,
    output logic            ex_stall,
    output logic            mem_valid,
    output logic [XLEN-1:0] mem_result,
    output logic [XLEN-1:0] mem_ForwardDataB
);

    localparam int SHW = $clog2(XLEN);

    typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, DONE = 2'd2} mdState_t;

    logic [XLEN-1:0] fwdA, fwdB, aluA, aluB, aluOut;
    logic [SHW-1:0]  shamt;
    logic            mdStall, mdDone;
    logic [XLEN-1:0] mdResult, mdStoreB;

    // Forwarding muxes (encoding 3 falls back to the ID/EX value)
    always_comb begin
        fwdA = ex_DataA;
        fwdB = ex_DataB;
        case (ForwardASel)
            2'd1:    fwdA = wb_WBData;
            2'd2:    fwdA = mem_ALU_out;
            default: fwdA = ex_DataA;
        endcase
        case (ForwardBSel)
            2'd1:    fwdB = wb_WBData;
            2'd2:    fwdB = mem_ALU_out;
            default: fwdB = ex_DataB;
        endcase
    end

    assign aluA  = id_ASel ? ex_pc : fwdA;
    assign aluB  = id_BSel ? imm : fwdB;
    assign shamt = aluB[SHW-1:0];

    // Single-cycle ALU
    always_comb begin
        aluOut = '0;
        case (ex_ALUSel)
            4'd0:    aluOut = aluA + aluB;
            4'd1:    aluOut = aluA - aluB;
            4'd2:    aluOut = aluA << shamt;
            4'd3:    aluOut = {{(XLEN-1){1'b0}}, ($signed(aluA) < $signed(aluB))};
            4'd4:    aluOut = {{(XLEN-1){1'b0}}, (aluA < aluB)};
            4'd5:    aluOut = aluA ^ aluB;
            4'd6:    aluOut = aluA >> shamt;
            4'd7:    aluOut = $unsigned($signed(aluA) >>> shamt);
            4'd8:    aluOut = aluA | aluB;
            4'd9:    aluOut = aluA & aluB;
            4'd10:   aluOut = aluB;
            default: aluOut = '0;
        endcase
    end

    assign ex_BrEq = (fwdA == fwdB);
    assign ex_BrLT = id_BrUn ? (fwdA < fwdB) : ($signed(fwdA) < $signed(fwdB));

    generate
        if (MD_EN) begin : gMd
            mdState_t          state, nextState;
            logic [SHW-1:0]    count;
            logic [XLEN-1:0]   hi, lo, magA, magB, storeB;
            logic [2:0]        sel;
            logic              negA, negB;
            logic              accept, aSignedIn, bSignedIn;
            logic [XLEN-1:0]   inMagA, inMagB, stepHi, stepLo;
            logic [XLEN:0]     mulSum, divRem;
            logic              divGe, divZero;
            logic [2*XLEN-1:0] prodFix;
            logic [XLEN-1:0]   quoFix, remFix, dividend;

            assign accept = (state == IDLE) & ex_valid & ex_is_md & ~ex_flush;

            // Operand signedness from funct3 and magnitude extraction
            always_comb begin
                aSignedIn = 1'b0;
                bSignedIn = 1'b0;
                case (ex_MDSel)
                    3'd1, 3'd4, 3'd6: begin
                        aSignedIn = 1'b1;
                        bSignedIn = 1'b1;
                    end
                    3'd2:    aSignedIn = 1'b1;
                    default: begin
                        aSignedIn = 1'b0;
                        bSignedIn = 1'b0;
                    end
                endcase
                inMagA = (aSignedIn & fwdA[XLEN-1]) ? -fwdA : fwdA;
                inMagB = (bSignedIn & fwdB[XLEN-1]) ? -fwdB : fwdB;
            end

            // One radix-2 step: hi:lo is product/multiplier or remainder/quotient
            always_comb begin
                mulSum = {1'b0, hi} + (lo[0] ? {1'b0, magA} : {(XLEN+1){1'b0}});
                divRem = {hi, lo[XLEN-1]};
                divGe  = (divRem >= {1'b0, magB});
                if (sel[2]) begin
                    stepHi = divGe ? (divRem[XLEN-1:0] - magB) : divRem[XLEN-1:0];
                    stepLo = {lo[XLEN-2:0], divGe};
                end else begin
                    stepHi = mulSum[XLEN:1];
                    stepLo = {mulSum[0], lo[XLEN-1:1]};
                end
            end

            // FSM state and iterative datapath registers
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    state  <= IDLE;
                    count  <= '0;
                    hi     <= '0;
                    lo     <= '0;
                    magA   <= '0;
                    magB   <= '0;
                    storeB <= '0;
                    sel    <= 3'd0;
                    negA   <= 1'b0;
                    negB   <= 1'b0;
                end else begin
                    state <= nextState;
                    if (accept) begin
                        count  <= '0;
                        hi     <= '0;
                        lo     <= ex_MDSel[2] ? inMagA : inMagB;
                        magA   <= inMagA;
                        magB   <= inMagB;
                        storeB <= fwdB;
                        sel    <= ex_MDSel;
                        negA   <= aSignedIn & fwdA[XLEN-1];
                        negB   <= bSignedIn & fwdB[XLEN-1];
                    end else if (state == BUSY) begin
                        count <= count + 1'b1;
                        hi    <= stepHi;
                        lo    <= stepLo;
                    end
                end
            end

            // Next-state logic; flush aborts an operation in flight
            always_comb begin
                nextState = state;
                case (state)
                    IDLE: begin
                        if (accept) nextState = BUSY;
                        else        nextState = IDLE;
                    end
                    BUSY: begin
                        if (ex_flush)                      nextState = IDLE;
                        else if (count == SHW'(XLEN - 1))  nextState = DONE;
                        else                               nextState = BUSY;
                    end
                    DONE:    nextState = IDLE;
                    default: nextState = IDLE;
                endcase
            end

            // Sign correction; divide-by-zero overrides, overflow falls out naturally
            always_comb begin
                mdResult = '0;
                prodFix  = (negA ^ negB) ? -{hi, lo} : {hi, lo};
                quoFix   = (negA ^ negB) ? -lo : lo;
                remFix   = negA ? -hi : hi;
                dividend = negA ? -magA : magA;
                divZero  = (magB == '0);
                case (sel)
                    3'd0:             mdResult = prodFix[XLEN-1:0];
                    3'd1, 3'd2, 3'd3: mdResult = prodFix[2*XLEN-1:XLEN];
                    3'd4, 3'd5:       mdResult = divZero ? '1 : quoFix;
                    default:          mdResult = divZero ? dividend : remFix;
                endcase
            end

            assign mdStall  = accept | (state == BUSY);
            assign mdDone   = (state == DONE);
            assign mdStoreB = storeB;
        end else begin : gNoMd
            assign mdStall  = 1'b0;
            assign mdDone   = 1'b0;
            assign mdResult = '0;
            assign mdStoreB = '0;
        end
    endgenerate

    assign ex_stall = mdStall & ~rst;

    // EX/MEM register: flush beats completion, stalls insert bubbles
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_valid        <= 1'b0;
            mem_result       <= '0;
            mem_ForwardDataB <= '0;
        end else if (ex_flush) begin
            mem_valid <= 1'b0;
        end else if (mdDone) begin
            mem_valid        <= 1'b1;
            mem_result       <= mdResult;
            mem_ForwardDataB <= mdStoreB;
        end else if (mdStall) begin
            mem_valid <= 1'b0;
        end else begin
            mem_valid        <= ex_valid;
            mem_result       <= aluOut;
            mem_ForwardDataB <= fwdB;
        end
    end

endmodule

// File: tb/tb_execute_unit_md.sv
// Randomised self-checking bench for execute_unit_md against an arithmetic reference model.
module tb_execute_unit_md;
    localparam int XLEN = 32;

    logic            clk;
    logic            rst;
    logic            ex_valid, ex_flush;
    logic [XLEN-1:0] ex_pc, ex_DataA, ex_DataB, imm, mem_ALU_out, wb_WBData;
    logic [1:0]      ForwardASel, ForwardBSel;
    logic            id_ASel, id_BSel, id_BrUn;
    logic [3:0]      ex_ALUSel;
    logic            ex_is_md;
    logic [2:0]      ex_MDSel;
    logic            ex_BrEq, ex_BrLT, ex_stall, mem_valid;
    logic [XLEN-1:0] mem_result, mem_ForwardDataB;

    int errors = 0;
    int checks = 0;

    execute_unit_md #(.XLEN(XLEN), .MD_EN(1'b1)) dut (
        .clk(clk), .rst(rst), .ex_valid(ex_valid), .ex_flush(ex_flush), .ex_pc(ex_pc),
        .ex_DataA(ex_DataA), .ex_DataB(ex_DataB), .imm(imm), .mem_ALU_out(mem_ALU_out),
        .wb_WBData(wb_WBData), .ForwardASel(ForwardASel), .ForwardBSel(ForwardBSel),
        .id_ASel(id_ASel), .id_BSel(id_BSel), .id_BrUn(id_BrUn), .ex_ALUSel(ex_ALUSel),
        .ex_is_md(ex_is_md), .ex_MDSel(ex_MDSel), .ex_BrEq(ex_BrEq), .ex_BrLT(ex_BrLT),
        .ex_stall(ex_stall), .mem_valid(mem_valid), .mem_result(mem_result),
        .mem_ForwardDataB(mem_ForwardDataB)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        if (obs !== expv) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, expv);
        end
    endtask

    function automatic logic [31:0] randVal();
        case ($urandom_range(0, 5))
            0:       return 32'h0;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h8000_0000;
            3:       return $urandom_range(0, 16);
            default: return $urandom;
        endcase
    endfunction

    function automatic logic [31:0] refAlu(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        case (op)
            4'd0:    return a + b;
            4'd1:    return a - b;
            4'd2:    return a << b[4:0];
            4'd3:    return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            4'd4:    return (a < b) ? 32'd1 : 32'd0;
            4'd5:    return a ^ b;
            4'd6:    return a >> b[4:0];
            4'd7:    return $unsigned($signed(a) >>> b[4:0]);
            4'd8:    return a | b;
            4'd9:    return a & b;
            4'd10:   return b;
            default: return 32'd0;
        endcase
    endfunction

    function automatic logic [31:0] refMd(input logic [2:0] sel, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb, ua, ub;
        logic [63:0] p;
        logic ovf;
        sa  = longint'($signed(a));
        sb  = longint'($signed(b));
        ua  = longint'({32'd0, a});
        ub  = longint'({32'd0, b});
        ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
        case (sel)
            3'd0: begin p = ua * ub; return p[31:0]; end
            3'd1: begin p = sa * sb; return p[63:32]; end
            3'd2: begin p = sa * ub; return p[63:32]; end
            3'd3: begin p = ua * ub; return p[63:32]; end
            3'd4: begin
                if (b == 32'd0) return 32'hFFFF_FFFF;
                if (ovf) return 32'h8000_0000;
                p = sa / sb; return p[31:0];
            end
            3'd5: begin
                if (b == 32'd0) return 32'hFFFF_FFFF;
                p = ua / ub; return p[31:0];
            end
            3'd6: begin
                if (b == 32'd0) return a;
                if (ovf) return 32'd0;
                p = sa % sb; return p[31:0];
            end
            default: begin
                if (b == 32'd0) return a;
                p = ua % ub; return p[31:0];
            end
        endcase
    endfunction

    // Route a and b through the requested forwarding sources, filling the rest with junk
    task automatic placeOps(input logic [1:0] fa, input logic [1:0] fb, input logic [31:0] a, input logic [31:0] b);
        ex_DataA = $urandom; ex_DataB = $urandom; wb_WBData = $urandom; mem_ALU_out = $urandom;
        if (fb == fa && (fa == 2'd1 || fa == 2'd2)) fb = 2'd0;
        ForwardASel = fa;
        ForwardBSel = fb;
        case (fa)
            2'd1:    wb_WBData = a;
            2'd2:    mem_ALU_out = a;
            default: ex_DataA = a;
        endcase
        case (fb)
            2'd1:    wb_WBData = b;
            2'd2:    mem_ALU_out = b;
            default: ex_DataB = b;
        endcase
    endtask

    task automatic issueAlu(input logic [3:0] op, input logic asel, input logic bsel, input logic brun,
                            input logic valid, input logic [1:0] fa, input logic [1:0] fb,
                            input logic [31:0] a, input logic [31:0] b);
        logic [31:0] pcv, immv, expv;
        @(negedge clk);
        placeOps(fa, fb, a, b);
        pcv = $urandom; immv = randVal();
        ex_pc = pcv; imm = immv; id_ASel = asel; id_BSel = bsel; id_BrUn = brun;
        ex_ALUSel = op; ex_is_md = 1'b0; ex_MDSel = 3'($urandom); ex_valid = valid; ex_flush = 1'b0;
        expv = refAlu(op, asel ? pcv : a, bsel ? immv : b);
        #1;
        check("brEq", ex_BrEq, a == b);
        check("brLT", ex_BrLT, brun ? (a < b) : ($signed(a) < $signed(b)));
        check("aluStall", ex_stall, 1'b0);
        @(posedge clk); #1;
        check("aluValid", mem_valid, valid);
        if (valid) begin
            check("aluResult", mem_result, expv);
            check("aluStoreB", mem_ForwardDataB, b);
        end
    endtask

    task automatic issueMd(input logic [2:0] sel, input logic [1:0] fa, input logic [1:0] fb,
                           input logic [31:0] a, input logic [31:0] b, input string tag);
        int n;
        logic bubbleBad;
        logic [31:0] expv;
        expv = refMd(sel, a, b);
        @(negedge clk);
        placeOps(fa, fb, a, b);
        ex_valid = 1'b1; ex_is_md = 1'b1; ex_flush = 1'b0; ex_MDSel = sel;
        ex_ALUSel = 4'($urandom); id_ASel = 1'($urandom); id_BSel = 1'($urandom);
        #1;
        n = 0;
        bubbleBad = 1'b0;
        while (ex_stall === 1'b1 && n < 200) begin
            n++;
            @(posedge clk); #1;
            if (mem_valid !== 1'b0) bubbleBad = 1'b1;
            ex_DataA = $urandom; ex_DataB = $urandom; wb_WBData = $urandom; mem_ALU_out = $urandom;
            ForwardASel = 2'($urandom); ForwardBSel = 2'($urandom); ex_MDSel = 3'($urandom);
        end
        check({tag, "Stall"}, n, XLEN + 1);
        check({tag, "Bubble"}, bubbleBad, 1'b0);
        @(posedge clk); #1;
        check({tag, "Valid"}, mem_valid, 1'b1);
        check({tag, "Result"}, mem_result, expv);
        ex_valid = 1'b0;
        ex_is_md = 1'b0;
    endtask

    initial begin
        rst = 1'b1; ex_valid = 1'b1; ex_is_md = 1'b1; ex_flush = 1'b0; ex_pc = '0;
        ex_DataA = '0; ex_DataB = '0; imm = '0; mem_ALU_out = '0; wb_WBData = '0;
        ForwardASel = 2'd0; ForwardBSel = 2'd0; id_ASel = 1'b0; id_BSel = 1'b0; id_BrUn = 1'b0;
        ex_ALUSel = 4'd0; ex_MDSel = 3'd0;
        repeat (2) @(posedge clk);
        #1;
        check("rstValid", mem_valid, 1'b0);
        check("rstResult", mem_result, 32'd0);
        check("rstStoreB", mem_ForwardDataB, 32'd0);
        check("rstStall", ex_stall, 1'b0);
        @(negedge clk);
        ex_valid = 1'b0; ex_is_md = 1'b0; rst = 1'b0;

        issueAlu(4'd0, 1'b0, 1'b0, 1'b0, 1'b1, 2'd2, 2'd0, 32'd5, 32'd7);
        check("add5p7", mem_result, 32'd12);
        issueAlu(4'd1, 1'b0, 1'b0, 1'b0, 1'b1, 2'd0, 2'd0, 32'hFFFF_FFFF, 32'd1);
        issueAlu(4'd1, 1'b0, 1'b0, 1'b1, 1'b1, 2'd0, 2'd0, 32'hFFFF_FFFF, 32'd1);

        issueMd(3'd3, 2'd0, 2'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "mulhu");
        issueMd(3'd0, 2'd0, 2'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "mul");
        issueMd(3'd1, 2'd0, 2'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "mulh");
        issueMd(3'd4, 2'd0, 2'd0, 32'hFFFF_FFF9, 32'd2, "divNeg");
        issueMd(3'd6, 2'd0, 2'd0, 32'hFFFF_FFF9, 32'd2, "remNeg");
        issueMd(3'd5, 2'd0, 2'd0, 32'd1234, 32'd0, "divuZero");
        issueMd(3'd6, 2'd0, 2'd0, 32'd9, 32'd0, "remZero");
        issueMd(3'd4, 2'd0, 2'd0, 32'h8000_0000, 32'hFFFF_FFFF, "divOvf");
        issueMd(3'd6, 2'd0, 2'd0, 32'h8000_0000, 32'hFFFF_FFFF, "remOvf");

        for (int i = 0; i < 40; i++) begin
            issueAlu(4'($urandom_range(0, 15)), 1'($urandom), 1'($urandom), 1'($urandom),
                     ($urandom_range(0, 7) != 0), 2'($urandom), 2'($urandom), randVal(), randVal());
        end
        for (int i = 0; i < 12; i++) begin
            issueMd(3'($urandom_range(0, 7)), 2'($urandom), 2'($urandom), randVal(), randVal(), "mdRand");
        end

        // Flush ten cycles into a divide
        @(negedge clk);
        placeOps(2'd0, 2'd0, 32'd100, 32'd7);
        ex_valid = 1'b1; ex_is_md = 1'b1; ex_MDSel = 3'd4; ex_flush = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        ex_flush = 1'b1;
        @(posedge clk); #1;
        check("flushValid", mem_valid, 1'b0);
        ex_flush = 1'b0; ex_valid = 1'b0; ex_is_md = 1'b0;
        #1;
        check("flushIdle", ex_stall, 1'b0);
        issueAlu(4'd0, 1'b0, 1'b0, 1'b0, 1'b1, 2'd0, 2'd0, 32'd40, 32'd2);

        // Flush blocks accept in IDLE
        @(negedge clk);
        placeOps(2'd0, 2'd0, 32'd6, 32'd3);
        ex_valid = 1'b1; ex_is_md = 1'b1; ex_MDSel = 3'd0; ex_flush = 1'b1;
        #1;
        check("flushAcceptStall", ex_stall, 1'b0);
        @(posedge clk); #1;
        check("flushAcceptValid", mem_valid, 1'b0);
        ex_flush = 1'b0; ex_valid = 1'b0; ex_is_md = 1'b0;
        #1;
        check("flushAcceptIdle", ex_stall, 1'b0);

        // Reset in the middle of a multiply
        issueAlu(4'd0, 1'b0, 1'b0, 1'b0, 1'b1, 2'd0, 2'd0, 32'd5, 32'd7);
        @(negedge clk);
        placeOps(2'd0, 2'd0, 32'd3, 32'd4);
        ex_valid = 1'b1; ex_is_md = 1'b1; ex_MDSel = 3'd0; ex_flush = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        check("midRstStall", ex_stall, 1'b0);
        check("midRstValid", mem_valid, 1'b0);
        check("midRstResult", mem_result, 32'd0);
        check("midRstStoreB", mem_ForwardDataB, 32'd0);
        ex_valid = 1'b0; ex_is_md = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        issueMd(3'd0, 2'd0, 2'd0, 32'd3, 32'd4, "mulAfterRst");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
